seg_scan: RTL

Multiplexed 4-digit scanner for the board's common-anode 7-segment display. Holds a 16-bit display value, cycles one digit at a time at a prescaled rate, and drives the 4-bit nibble that the downstream hex-to-segment decoder (active-low segments) converts. Also drives active-low digit enables. New values are accepted through a write strobe and committed only at a frame boundary, so a half-updated frame is never displayed.

---
 rtl/seg_pkg.sv | 25 ++
 rtl/seg_tick.sv | 29 ++
 rtl/seg_scan.sv | 80 ++++++++
 3 files changed

// File: rtl/seg_pkg.sv
// Shared constants and helpers for the 4-digit 7-segment scanner.
// Leading-zero blanking helper is used when SEG_SCAN_LZB_EN is defined.
package seg_pkg;

  localparam int NDIG        = 4;
  localparam int DIV_DEFAULT = 50000;
  localparam int IDXW        = 2;

  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NDIG - 1);

  // A digit is blanked when it and every digit to its left are zero.
  // Digit 0 is never blanked so that a zero value still shows "0".
  function automatic logic [NDIG-1:0] lzb_mask(input logic [4*NDIG-1:0] v);
    logic [NDIG-1:0] m;
    logic            z;
    m = '0;
    z = 1'b1;
    for (int k = NDIG - 1; k > 0; k--) begin
      z    = z & (v[4*k +: 4] == 4'h0);
      m[k] = z;
    end
    return m;
  endfunction

endpackage

// File: rtl/seg_tick.sv
// Digit-slot prescaler: counts 0..DIV-1 and pulses tick on the last count.
module seg_tick
  import seg_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick
);

  localparam int            CW   = $clog2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/seg_scan.sv
// Multiplexed 4-digit scanner with frame-boundary commit of new values.
// Define SEG_SCAN_LZB_EN to enable leading-zero blanking of the digit enables.
module seg_scan
  import seg_pkg::*;
#(
  parameter int DIV = DIV_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr,
  input  logic [15:0] wdata,
  output logic        ack,
  output logic        pend,
  output logic [3:0]  ans,
  output logic [3:0]  dig
);

  logic            tick;
  logic [IDXW-1:0] idx;
  logic [15:0]     disp;
  logic [15:0]     hold;
  logic [NDIG-1:0] sel;
  logic [NDIG-1:0] blank;
  logic            boundary;

  seg_tick #(.DIV(DIV)) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (tick)
  );

  assign boundary = tick && (idx == IDX_LAST);

  // A write landing on the commit edge still commits the older hold value;
  // the new value then waits a full frame with pend kept high.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx  <= '0;
      disp <= '0;
      hold <= '0;
      pend <= 1'b0;
      ack  <= 1'b0;
    end else begin
      ack <= 1'b0;
      if (tick) begin
        idx <= idx + IDXW'(1);
      end
      if (boundary && pend) begin
        disp <= hold;
        pend <= 1'b0;
        ack  <= 1'b1;
      end
      if (wr) begin
        hold <= wdata;
        pend <= 1'b1;
      end
    end
  end

  always_comb begin
    ans = 4'h0;
    case (idx)
      2'd0:    ans = disp[3:0];
      2'd1:    ans = disp[7:4];
      2'd2:    ans = disp[11:8];
      default: ans = disp[15:12];
    endcase
  end

  assign sel = NDIG'(1) << idx;

`ifdef SEG_SCAN_LZB_EN
  assign blank = lzb_mask(disp);
`else
  assign blank = '0;
`endif

  assign dig = ~(sel & ~blank);

endmodule
